mem_access_ctrl: RTL and testbench

Initiator-side controller for the 256x8 data memory.
- Accepts single or burst load/store requests from the datapath through a valid/ready handshake.
- Drives the memory's mem_read, mem_write, address and write-data inputs, and captures its registered read data.
- Hides the fixed read latency and returns load data as a valid-qualified stream.
- Sits between the datapath/ALU and the data memory.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_access_ctrl_if.sv | 35 +++
 rtl/mem_access_ctrl_rd_lat_pipe.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding, default widths and the burst range helper for the data-memory access controller.
package mem_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DRAIN
  } state_t;

  // True when the last beat of a burst starting at addr would lie past the top address.
  function automatic logic burst_overflows(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    logic [ADDR_W:0] last_addr;
    last_addr = {1'b0, addr} + (ADDR_W + 1)'(len);
    return last_addr[ADDR_W];
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, store-data, load-return and memory-side signals of the access controller.
// master = datapath plus memory environment, slave = the controller itself.
interface mem_access_ctrl_if import mem_ctrl_pkg::*; ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, mem_rdata,
    input  req_ready, wr_ready, rd_data, rd_valid, done, err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, mem_rdata,
    output req_ready, wr_ready, rd_data, rd_valid, done, err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_access_ctrl_rd_lat_pipe.sv
// Valid shift register tracking issued reads through the memory's fixed read latency.
// empty means no beat is queued behind the one currently at the output stage.
module rd_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic valid,
  output logic empty
);

  logic [DEPTH-1:0] stage_reg;
  logic [DEPTH-1:0] stage_next;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = in_valid & ~flush;
      end else begin : g_tail
        assign stage_next[gi] = stage_reg[gi-1] & ~flush;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign valid = stage_reg[DEPTH-1];

  generate
    if (DEPTH == 1) begin : g_single
      assign empty = 1'b1;
    end else begin : g_multi
      assign empty = ~|stage_reg[DEPTH-2:0];
    end
  endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// Burst load/store initiator for the 256x8 data memory; hides the read latency behind a valid stream.
// Define MEM_ACCESS_BOUND_CHECK_EN to reject bursts running past the top address with an err pulse.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              req_rdy, wr_rdy, rd_strobe, wr_strobe;
  logic              rd_issue;
  logic              oob;
  logic              pipe_valid, pipe_empty;

`ifdef MEM_ACCESS_BOUND_CHECK_EN
  assign oob = burst_overflows(bus.req_addr, bus.req_len);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    req_rdy    = 1'b0;
    wr_rdy     = 1'b0;
    rd_strobe  = 1'b0;
    wr_strobe  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_rdy = 1'b1;
        if (bus.req_valid) begin
          if (oob) begin
            err_next = 1'b1;
          end else begin
            addr_next  = bus.req_addr;
            cnt_next   = bus.req_len;
            state_next = bus.req_write ? WR : RD;
          end
        end
      end
      WR: begin
        wr_rdy    = 1'b1;
        wr_strobe = bus.wr_valid;
        if (bus.wr_valid) begin
          addr_next = addr_reg + 1'b1;
          cnt_next  = cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      RD: begin
        rd_strobe = 1'b1;
        addr_next = addr_reg + 1'b1;
        cnt_next  = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The final beat leaves the pipe on the same edge that returns us to IDLE.
        if (pipe_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign rd_issue = rd_strobe & ~rst;

  rd_lat_pipe #(
    .DEPTH (READ_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (state_reg == IDLE),
    .in_valid (rd_issue),
    .valid    (pipe_valid),
    .empty    (pipe_empty)
  );

  assign bus.req_ready = req_rdy;
  assign bus.wr_ready  = wr_rdy & ~rst;
  assign bus.mem_read  = rd_issue;
  assign bus.mem_write = wr_strobe & ~rst;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = bus.wr_data;
  assign bus.rd_valid  = pipe_valid;
  assign bus.rd_data   = pipe_valid ? bus.mem_rdata : '0;
  // Store completion is registered; load completion rides on the final returning beat.
  assign bus.done      = done_reg | ((state_reg == DRAIN) & pipe_valid & pipe_empty);
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of bursts plus hand-written corner sequences,
// with a READ_LAT=1 instance and a READ_LAT=2 instance, each in front of a behavioural memory.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();
  mem_access_ctrl_if bus2 ();

  mem_access_ctrl #(.READ_LAT(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_access_ctrl #(.READ_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Behavioural memories: registered read, 1 stage for dut, 2 stages for dut2.
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic [7:0] m1_q;
  logic [7:0] m2_q [2];

  always @(posedge clk) begin
    if (bus.mem_write) mem1[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read)  m1_q <= mem1[bus.mem_addr];
    if (bus2.mem_read) m2_q[0] <= mem2[bus2.mem_addr];
    m2_q[1] <= m2_q[0];
  end
  assign bus.mem_rdata  = m1_q;
  assign bus2.mem_rdata = m2_q[1];

  // Cycle counter and event logs, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int w_addr[$], w_data[$], w_cyc[$], r_addr[$], r_cyc[$];
  int rv_data[$], rv_cyc[$], done_cyc[$], err_cyc[$];
  int r2_cyc[$], rv2_data[$], rv2_cyc[$], done2_cyc[$];
  int overlap = 0;
  int err_total = 0;

  always @(negedge clk) begin
    if (bus.mem_write) begin
      w_addr.push_back(int'(bus.mem_addr));
      w_data.push_back(int'(bus.mem_wdata));
      w_cyc.push_back(cyc);
    end
    if (bus.mem_read) begin
      r_addr.push_back(int'(bus.mem_addr));
      r_cyc.push_back(cyc);
    end
    if (bus.rd_valid) begin
      rv_data.push_back(int'(bus.rd_data));
      rv_cyc.push_back(cyc);
    end
    if (bus.done) done_cyc.push_back(cyc);
    if (bus.err) begin
      err_cyc.push_back(cyc);
      err_total++;
    end
    if (bus.mem_read && bus.mem_write) overlap++;
    if (bus2.mem_read && bus2.mem_write) overlap++;
    if (bus2.mem_read) r2_cyc.push_back(cyc);
    if (bus2.rd_valid) begin
      rv2_data.push_back(int'(bus2.rd_data));
      rv2_cyc.push_back(cyc);
    end
    if (bus2.done) done2_cyc.push_back(cyc);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    w_addr.delete(); w_data.delete(); w_cyc.delete(); r_addr.delete(); r_cyc.delete();
    rv_data.delete(); rv_cyc.delete(); done_cyc.delete(); err_cyc.delete();
    r2_cyc.delete(); rv2_data.delete(); rv2_cyc.delete(); done2_cyc.delete();
  endtask

  task automatic send_req(input bit wr, input int addr, input int len, input bit hold, output int acc_cyc);
    int guard;
    guard = 0;
    bus.req_write = wr;
    bus.req_addr  = 8'(addr);
    bus.req_len   = 4'(len);
    bus.req_valid = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.req_ready && guard < 20);
    chk("req_ready_idle", int'(bus.req_ready), 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  typedef struct {
    bit wr;
    int addr;
    int len;
    int seed;       // first data beat; each following beat is +1
    int gap;        // beats accepted before a one-cycle wr_valid gap, -1 for none
    int exp_beats;
    int exp_end;    // address of the last beat
  } vec_t;

  function automatic vec_t mkv(bit wr, int addr, int len, int seed, int gap, int beats, int end_addr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.seed = seed; v.gap = gap;
    v.exp_beats = beats; v.exp_end = end_addr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int  i, guard, acc_c, last;
    bit  gapped, acc;
    clear_logs();
    send_req(v.wr, v.addr, v.len, 1'b0, acc_c);
    if (v.wr) begin
      i = 0; guard = 0; gapped = 0;
      while (i < v.len + 1 && guard < 64) begin
        if (i == v.gap && !gapped) begin
          bus.wr_valid = 1'b0;
          gapped = 1;
        end else begin
          bus.wr_valid = 1'b1;
          bus.wr_data  = 8'(v.seed + i);
        end
        @(negedge clk);
        acc = bus.wr_valid && bus.wr_ready;
        @(posedge clk); #1;
        if (acc) i++;
        guard++;
      end
      bus.wr_valid = 1'b0;
    end
    repeat (v.len + 6) @(posedge clk);
    #1;
    last = v.exp_beats - 1;
    if (v.wr) begin
      chk("store_beats", w_addr.size(), v.exp_beats);
      for (int k = 0; k < v.exp_beats; k++) begin
        chk("store_addr", qat(w_addr, k), (v.addr + k) % 256);
        chk("store_data", qat(w_data, k), (v.seed + k) % 256);
        if (k > 0) chk("store_spacing", qat(w_cyc, k) - qat(w_cyc, k - 1), (k == v.gap) ? 2 : 1);
      end
      chk("store_end_addr", qat(w_addr, last), v.exp_end);
      chk("store_no_reads", r_addr.size(), 0);
      chk("store_done_cnt", done_cyc.size(), 1);
      chk("store_done_time", qat(done_cyc, 0) - qat(w_cyc, last), 1);
    end else begin
      chk("load_issues", r_addr.size(), v.exp_beats);
      chk("load_rd_cnt", rv_data.size(), v.exp_beats);
      for (int k = 0; k < v.exp_beats; k++) begin
        chk("load_addr", qat(r_addr, k), (v.addr + k) % 256);
        chk("load_data", qat(rv_data, k), (v.seed + k) % 256);
        chk("load_latency", qat(rv_cyc, k) - qat(r_cyc, k), 1);
        if (k > 0) chk("issue_spacing", qat(r_cyc, k) - qat(r_cyc, k - 1), 1);
      end
      chk("load_end_addr", qat(r_addr, last), v.exp_end);
      chk("load_no_writes", w_addr.size(), 0);
      chk("load_done_cnt", done_cyc.size(), 1);
      chk("load_done_time", qat(done_cyc, 0), qat(rv_cyc, last));
    end
    $display("[TB] vec %s addr=0x%02h len=%0d beats=%0d writes=%0d reads=%0d rd_valid=%0d done=%0d",
             v.wr ? "store" : "load ", v.addr, v.len, v.exp_beats, w_addr.size(), r_addr.size(),
             rv_data.size(), done_cyc.size());
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_c, hs, hs_c;
    bit hs_now;

    for (int i = 0; i < 4; i++) mem2[8'h40 + i] = 8'(8'hC0 + i);

    vecs.push_back(mkv(1, 'h10, 0,  'hA5, -1, 1,  'h10));
    vecs.push_back(mkv(0, 'h10, 0,  'hA5, -1, 1,  'h10));
    vecs.push_back(mkv(1, 'h20, 3,  'h01,  2, 4,  'h23));
    vecs.push_back(mkv(0, 'h20, 3,  'h01, -1, 4,  'h23));
`ifndef MEM_ACCESS_BOUND_CHECK_EN
    vecs.push_back(mkv(1, 'hFE, 2,  'h70, -1, 3,  'h00));
    vecs.push_back(mkv(0, 'hFE, 2,  'h70, -1, 3,  'h00));
`endif
    vecs.push_back(mkv(0, 'h21, 1,  'h02, -1, 2,  'h22));
    vecs.push_back(mkv(1, 'h80, 15, 'h30,  5, 16, 'h8F));
    vecs.push_back(mkv(0, 'h8E, 1,  'h3E, -1, 2,  'h8F));

    rst = 1'b1;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_len = 0;
    bus.wr_data = 0; bus.wr_valid = 0;
    bus2.req_valid = 0; bus2.req_write = 0; bus2.req_addr = 0; bus2.req_len = 0;
    bus2.wr_data = 0; bus2.wr_valid = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_read",  int'(bus.mem_read), 0);
    chk("rst_mem_write", int'(bus.mem_write), 0);
    chk("rst_wr_ready",  int'(bus.wr_ready), 0);
    chk("rst_rd_valid",  int'(bus.rd_valid), 0);
    chk("rst_done",      int'(bus.done), 0);
    chk("rst_err",       int'(bus.err), 0);
    chk("rst_rd_data",   int'(bus.rd_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", int'(bus.req_ready), 1);
    @(posedge clk); #1;

    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

    // Request held during a load burst: accepted exactly once, only after returning to IDLE.
    clear_logs();
    send_req(0, 'h20, 3, 1'b1, acc_c);
    bus.req_addr = 8'h10;
    bus.req_len  = 4'd0;
    hs = 0; hs_c = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      hs_now = bus.req_valid && bus.req_ready;
      if (hs_now) begin
        hs++;
        hs_c = cyc;
      end
      @(posedge clk); #1;
      if (hs_now) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    chk("bp_accept_cnt", hs, 1);
    chk("bp_accept_time", hs_c, qat(done_cyc, 0) + 1);
    chk("bp_done_cnt", done_cyc.size(), 2);
    chk("bp_rd_cnt", rv_data.size(), 5);
    chk("bp_second_data", qat(rv_data, 4), 'hA5);
    $display("[TB] seq backpressure accepts=%0d rd_valid=%0d done=%0d", hs, rv_data.size(), done_cyc.size());

    // Reset while beat 2 of a len-7 load is being issued.
    clear_logs();
    send_req(0, 'h80, 7, 1'b0, acc_c);
    @(posedge clk); #2;
    chk("mid_pre_mem_read", int'(bus.mem_read), 1);
    chk("mid_pre_rd_valid", int'(bus.rd_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_mem_read",  int'(bus.mem_read), 0);
    chk("mid_mem_write", int'(bus.mem_write), 0);
    chk("mid_rd_valid",  int'(bus.rd_valid), 0);
    chk("mid_done",      int'(bus.done), 0);
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_after_reads",  r_addr.size(), 0);
    chk("mid_after_rd",     rv_data.size(), 0);
    chk("mid_after_done",   done_cyc.size(), 0);
    chk("mid_after_writes", w_addr.size(), 0);
    chk("mid_req_ready",    int'(bus.req_ready), 1);
    $display("[TB] seq reset_mid_load reads=%0d rd_valid=%0d done=%0d", r_addr.size(), rv_data.size(), done_cyc.size());
    @(posedge clk); #1;

    // READ_LAT=2 instance: load 0x40 len 3.
    clear_logs();
    bus2.req_write = 1'b0;
    bus2.req_addr  = 8'h40;
    bus2.req_len   = 4'd3;
    bus2.req_valid = 1'b1;
    @(negedge clk);
    chk("lat2_req_ready", int'(bus2.req_ready), 1);
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("lat2_issues", r2_cyc.size(), 4);
    chk("lat2_rd_cnt", rv2_data.size(), 4);
    chk("lat2_first_latency", qat(rv2_cyc, 0) - qat(r2_cyc, 0), 2);
    for (int k = 0; k < 4; k++) begin
      chk("lat2_data", qat(rv2_data, k), 'hC0 + k);
      if (k > 0) chk("lat2_spacing", qat(rv2_cyc, k) - qat(rv2_cyc, k - 1), 1);
    end
    chk("lat2_done_cnt", done2_cyc.size(), 1);
    chk("lat2_done_time", qat(done2_cyc, 0), qat(rv2_cyc, 3));
    $display("[TB] seq read_lat2 reads=%0d rd_valid=%0d done=%0d", r2_cyc.size(), rv2_data.size(), done2_cyc.size());

`ifdef MEM_ACCESS_BOUND_CHECK_EN
    // Out-of-range store is consumed but not executed.
    clear_logs();
    send_req(1, 'hFE, 2, 1'b0, acc_c);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bound_err_cnt", err_cyc.size(), 1);
    chk("bound_err_time", qat(err_cyc, 0), acc_c + 1);
    chk("bound_no_writes", w_addr.size(), 0);
    chk("bound_no_done", done_cyc.size(), 0);
    chk("bound_idle", int'(bus.req_ready), 1);
    $display("[TB] seq bound_check err=%0d writes=%0d", err_cyc.size(), w_addr.size());
`else
    chk("err_never", err_total, 0);
`endif

    chk("rd_wr_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
